// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory: access encodings,
// sequencer states and small decode helpers.
package dmem_pkg;

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_HS = 3'b001;
  localparam logic [2:0] OP_HU = 3'b010;
  localparam logic [2:0] OP_BS = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;

  localparam int WORD_BYTES = 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Encodings above OP_BU have no defined access type.
  function automatic logic op_illegal(input logic [2:0] op);
    return (op > OP_BU);
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic: selects/extends the load lane, merges store
// data into the addressed lane and flags misaligned word/half accesses.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  op,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged,
  output logic        misalign
);

  logic [15:0] half_s;
  logic [7:0]  byte_s;

  // Pick the addressed halfword and byte lanes out of the stored word
  always_comb begin
    half_s = 16'h0000;
    byte_s = 8'h00;
    if (byte_off[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
    case (byte_off)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = 8'h00;
    endcase
  end

  // Extend the load lane, build the merged store word, check alignment
  always_comb begin
    load_val = 32'h0000_0000;
    merged   = word;
    misalign = 1'b0;
    case (op)
      OP_W: begin
        load_val = word;
        merged   = wdata;
        misalign = (byte_off != 2'd0);
      end
      OP_HS, OP_HU: begin
        if (op == OP_HS) begin
          load_val = {{16{half_s[15]}}, half_s};
        end else begin
          load_val = {16'h0000, half_s};
        end
        if (byte_off[1]) begin
          merged = {wdata[15:0], word[15:0]};
        end else begin
          merged = {word[31:16], wdata[15:0]};
        end
        misalign = byte_off[0];
      end
      OP_BS, OP_BU: begin
        if (op == OP_BS) begin
          load_val = {{24{byte_s[7]}}, byte_s};
        end else begin
          load_val = {24'h00_0000, byte_s};
        end
        case (byte_off)
          2'd0:    merged = {word[31:8], wdata[7:0]};
          2'd1:    merged = {word[31:16], wdata[7:0], word[7:0]};
          2'd2:    merged = {word[31:24], wdata[7:0], word[15:0]};
          2'd3:    merged = {wdata[7:0], word[23:0]};
          default: merged = word;
        endcase
        misalign = 1'b0;
      end
      default: begin
        load_val = 32'h0000_0000;
        merged   = word;
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_bytelane.sv
// MEM-stage data memory with byte/halfword access, a post-reset zero-fill
// sequencer, access error detection and a registered store-trace port.
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 3072,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memAdr,
  input  logic        memWrite,
  input  logic [2:0]  memOp,
  input  logic [31:0] wdata,
  input  logic [31:0] wPc,
  output logic [31:0] memOut,
  output logic        memReady,
  output logic        memErr,
  output logic        trValid,
  output logic [31:0] trPc,
  output logic [31:0] trAdr,
  output logic [31:0] trData
);

  localparam int              IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0]     DEPTH_W32 = 32'(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  logic [31:0]      mem [DEPTH_WORDS];

  state_t           state_r;
  logic [IDX_W-1:0] clr_idx_r;
  logic             ready_r;
  logic             tr_valid_r;
  logic [31:0]      tr_pc_r;
  logic [31:0]      tr_adr_r;
  logic [31:0]      tr_data_r;

  logic [31:0]      offset_s;
  logic [29:0]      quot_s;
  logic [IDX_W-1:0] index_s;
  logic             range_err_s;
  logic             mem_err_s;
  logic [31:0]      rd_word_s;
  logic [31:0]      load_val_s;
  logic [31:0]      merged_s;
  logic             misalign_s;
  logic             store_ok_s;
  logic [31:0]      out_s;

  // Full-width index; underflow and the untruncated quotient drive range errors
  always_comb begin
    offset_s    = memAdr - BASE_ADDR;
    quot_s      = offset_s[31:2];
    index_s     = quot_s[IDX_W-1:0];
    range_err_s = (memAdr < BASE_ADDR) || ({2'b00, quot_s} >= DEPTH_W32);
  end

  // Fetch the addressed word only when the index is inside the array
  always_comb begin
    rd_word_s = 32'h0000_0000;
    if (range_err_s) begin
      rd_word_s = 32'h0000_0000;
    end else begin
      rd_word_s = mem[index_s];
    end
  end

  // BASE_ADDR is word aligned, so the low offset bits equal memAdr[1:0]
  dmem_lane_unit u_lane (
    .word     (rd_word_s),
    .byte_off (offset_s[1:0]),
    .op       (memOp),
    .wdata    (wdata),
    .load_val (load_val_s),
    .merged   (merged_s),
    .misalign (misalign_s)
  );

  // Error, store acceptance and gated load result
  always_comb begin
    mem_err_s  = op_illegal(memOp) || misalign_s || range_err_s;
    store_ok_s = (state_r == ST_READY) && memWrite && !mem_err_s;
    out_s      = 32'h0000_0000;
    if ((state_r == ST_CLEAR) || mem_err_s) begin
      out_s = 32'h0000_0000;
    end else begin
      out_s = load_val_s;
    end
  end

  // Clear sequencer, ready flag and store-trace registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_CLEAR;
      clr_idx_r  <= {IDX_W{1'b0}};
      ready_r    <= 1'b0;
      tr_valid_r <= 1'b0;
      tr_pc_r    <= 32'h0000_0000;
      tr_adr_r   <= 32'h0000_0000;
      tr_data_r  <= 32'h0000_0000;
    end else begin
      tr_valid_r <= 1'b0;
      case (state_r)
        ST_CLEAR: begin
          if (clr_idx_r == LAST_IDX) begin
            state_r   <= ST_READY;
            ready_r   <= 1'b1;
            clr_idx_r <= {IDX_W{1'b0}};
          end else begin
            clr_idx_r <= clr_idx_r + IDX_W'(1);
          end
        end
        ST_READY: begin
          if (store_ok_s) begin
            tr_valid_r <= 1'b1;
            tr_pc_r    <= wPc;
            tr_adr_r   <= BASE_ADDR + {quot_s, 2'b00};
            tr_data_r  <= merged_s;
          end
        end
        default: begin
          state_r   <= ST_CLEAR;
          clr_idx_r <= {IDX_W{1'b0}};
          ready_r   <= 1'b0;
        end
      endcase
    end
  end

  // Single array write port: zero fill while clearing, merged word on a store
  always_ff @(posedge clk) begin
    if (state_r == ST_CLEAR) begin
      mem[clr_idx_r] <= 32'h0000_0000;
    end else if (store_ok_s) begin
      mem[index_s] <= merged_s;
    end
  end

  assign memOut   = out_s;
  assign memErr   = mem_err_s;
  assign memReady = ready_r;
  assign trValid  = tr_valid_r;
  assign trPc     = tr_pc_r;
  assign trAdr    = tr_adr_r;
  assign trData   = tr_data_r;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Self-checking bench for dmem_bytelane: an array-level model compared on
// every falling edge, plus directed vectors with literal expectations.
module tb_dmem_bytelane;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] memAdr = 32'h0;
  logic        memWrite = 1'b0;
  logic [2:0]  memOp = 3'b000;
  logic [31:0] wdata = 32'h0;
  logic [31:0] wPc = 32'h0;
  logic [31:0] memOut;
  logic        memReady;
  logic        memErr;
  logic        trValid;
  logic [31:0] trPc;
  logic [31:0] trAdr;
  logic [31:0] trData;

  dmem_bytelane #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .memAdr(memAdr), .memWrite(memWrite),
    .memOp(memOp), .wdata(wdata), .wPc(wPc), .memOut(memOut),
    .memReady(memReady), .memErr(memErr), .trValid(trValid),
    .trPc(trPc), .trAdr(trAdr), .trData(trData)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [DEPTH];
  int          m_edges = 0;
  logic        m_ready = 1'b0;
  logic        m_trv = 1'b0;
  logic [31:0] m_trpc = 32'h0;
  logic [31:0] m_tradr = 32'h0;
  logic [31:0] m_trdata = 32'h0;
  logic [31:0] m_exp_out;

  initial foreach (m_mem[i]) m_mem[i] = 32'h0;

  function automatic bit m_err(input logic [31:0] a, input logic [2:0] op);
    logic [31:0] d;
    d = a - BASE;
    if (op > 3'd4) return 1'b1;
    if (op == 3'd0 && (a % 4) != 0) return 1'b1;
    if ((op == 3'd1 || op == 3'd2) && (a % 2) != 0) return 1'b1;
    if (a < BASE) return 1'b1;
    if ((d / 4) >= 32'(DEPTH)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] op);
    logic [31:0] w, v;
    w = m_mem[m_idx(a)];
    v = w >> (8 * (a % 4));
    case (op)
      3'd0: return w;
      3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v + 32'hFFFF_0000; return v; end
      3'd2: return v & 32'hFFFF;
      3'd3: begin v = v & 32'hFF; if (v >= 32'h80) v = v + 32'hFFFF_FF00; return v; end
      3'd4: return v & 32'hFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] a,
                                          input logic [2:0] op, input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    sh = 8 * (a % 4);
    if (op == 3'd0) mask = 32'hFFFF_FFFF;
    else if (op <= 3'd2) mask = 32'h0000_FFFF << sh;
    else mask = 32'h0000_00FF << sh;
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  // Model state update: clear countdown, stores and trace
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_edges  <= 0;
      m_ready  <= 1'b0;
      m_trv    <= 1'b0;
      m_trpc   <= 32'h0;
      m_tradr  <= 32'h0;
      m_trdata <= 32'h0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= 32'h0;
    end else begin
      m_trv <= 1'b0;
      if (!m_ready) begin
        m_edges <= m_edges + 1;
        if (m_edges == DEPTH - 1) m_ready <= 1'b1;
      end else if (memWrite && !m_err(memAdr, memOp)) begin
        m_mem[m_idx(memAdr)] <= m_merge(m_mem[m_idx(memAdr)], memAdr, memOp, wdata);
        m_trv    <= 1'b1;
        m_trpc   <= wPc;
        m_tradr  <= BASE + 32'(4 * m_idx(memAdr));
        m_trdata <= m_merge(m_mem[m_idx(memAdr)], memAdr, memOp, wdata);
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    m_exp_out = 32'h0;
    if (m_ready && !m_err(memAdr, memOp)) m_exp_out = m_load(memAdr, memOp);
    check("model.memReady", {31'h0, memReady}, {31'h0, m_ready});
    check("model.memErr", {31'h0, memErr}, {31'h0, m_err(memAdr, memOp)});
    check("model.memOut", memOut, m_exp_out);
    check("model.trValid", {31'h0, trValid}, {31'h0, m_trv});
    check("model.trPc", trPc, m_trpc);
    check("model.trAdr", trAdr, m_tradr);
    check("model.trData", trData, m_trdata);
  end

  // ---------------- directed stimulus ----------------
  task automatic probe(input string name, input logic we, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc,
                       input logic exp_err, input logic [31:0] exp_out);
    memWrite = we; memOp = op; memAdr = a; wdata = d; wPc = pc;
    @(negedge clk);
    check({name, ".err"}, {31'h0, memErr}, {31'h0, exp_err});
    check({name, ".out"}, memOut, exp_out);
    @(posedge clk); #1;
    memWrite = 1'b0;
  endtask

  task automatic clear_wait();
    memWrite = 1'b1; memOp = 3'd0; memAdr = 32'h8; wdata = 32'hDEAD_BEEF; wPc = 32'h44;
    for (int i = 1; i <= DEPTH; i++) begin
      @(posedge clk); #1;
      check("clear.ready", {31'h0, memReady}, {31'h0, (i == DEPTH)});
      check("clear.trValid", {31'h0, trValid}, 32'h0);
    end
    memWrite = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", {31'h0, memReady}, 32'h0);
    check("rst.trData", trData, 32'h0);
    reset = 1'b0;
    clear_wait();
    for (int k = 0; k < DEPTH; k++) probe("zero", 1'b0, 3'd0, 32'(4 * k), 32'h0, 32'h0, 1'b0, 32'h0);

    probe("sw4", 1'b1, 3'd0, 32'h4, 32'h8765_4321, 32'h3000, 1'b0, 32'h0);
    check("sw4.trValid", {31'h0, trValid}, 32'h1);
    check("sw4.trPc", trPc, 32'h3000);
    check("sw4.trAdr", trAdr, 32'h4);
    check("sw4.trData", trData, 32'h8765_4321);
    probe("lw4", 1'b0, 3'd0, 32'h4, 32'h0, 32'h0, 1'b0, 32'h8765_4321);
    probe("sb6", 1'b1, 3'd3, 32'h6, 32'h0000_00AB, 32'h3004, 1'b0, 32'h0000_0065);
    check("sb6.trData", trData, 32'h87AB_4321);
    probe("sh4", 1'b1, 3'd1, 32'h4, 32'h0000_FFEE, 32'h3008, 1'b0, 32'h0000_4321);
    check("sh4.trData", trData, 32'h87AB_FFEE);
    probe("lb6", 1'b0, 3'd3, 32'h6, 32'h0, 32'h0, 1'b0, 32'hFFFF_FFAB);
    probe("lbu6", 1'b0, 3'd4, 32'h6, 32'h0, 32'h0, 1'b0, 32'h0000_00AB);
    probe("lh4", 1'b0, 3'd1, 32'h4, 32'h0, 32'h0, 1'b0, 32'hFFFF_FFEE);
    probe("lhu4", 1'b0, 3'd2, 32'h4, 32'h0, 32'h0, 1'b0, 32'h0000_FFEE);
    probe("lhs6", 1'b0, 3'd1, 32'h6, 32'h0, 32'h0, 1'b0, 32'hFFFF_87AB);
    probe("lbu7", 1'b0, 3'd4, 32'h7, 32'h0, 32'h0, 1'b0, 32'h0000_0087);

    probe("sw2", 1'b1, 3'd0, 32'h2, 32'h1111_1111, 32'h5000, 1'b1, 32'h0);
    check("sw2.trValid", {31'h0, trValid}, 32'h0);
    probe("sh5", 1'b1, 3'd1, 32'h5, 32'h2222, 32'h5004, 1'b1, 32'h0);
    probe("sw40", 1'b1, 3'd0, 32'h40, 32'h3333_3333, 32'h5008, 1'b1, 32'h0);
    probe("op5", 1'b0, 3'b101, 32'h4, 32'h0, 32'h0, 1'b1, 32'h0);
    probe("lw0", 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    probe("lw4b", 1'b0, 3'd0, 32'h4, 32'h0, 32'h0, 1'b0, 32'h87AB_FFEE);

    for (int k = 0; k < DEPTH; k++) begin
      memWrite = 1'b1; memOp = 3'd0; memAdr = 32'(4 * k);
      wdata = 32'(7 + 4 * k); wPc = 32'(32'h100 + 4 * k);
      @(posedge clk); #1;
      check("sweep.trValid", {31'h0, trValid}, 32'h1);
      check("sweep.trAdr", trAdr, 32'(4 * k));
      check("sweep.trData", trData, 32'(7 + 4 * k));
    end
    memWrite = 1'b0;
    for (int k = 0; k < DEPTH; k++) probe("sweep.rd", 1'b0, 3'd0, 32'(4 * k), 32'h0, 32'h0, 1'b0, 32'(7 + 4 * k));

    memAdr = 32'h4; memOp = 3'd0;
    reset = 1'b1; #1;
    check("rst2.trPc", trPc, 32'h0);
    check("rst2.trData", trData, 32'h0);
    check("rst2.memOut", memOut, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset = 1'b1; #1;
    check("rst3.ready", {31'h0, memReady}, 32'h0);
    check("rst3.memOut", memOut, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    clear_wait();
    probe("post.lw4", 1'b0, 3'd0, 32'h4, 32'h0, 32'h0, 1'b0, 32'h0);
    probe("post.lw3c", 1'b0, 3'd0, 32'h3C, 32'h0, 32'h0, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
